// File: rtl/cc_line_rd_responder_if.sv
// ============================================================================
// cc_line_rd_responder_if
// ----------------------------------------------------------------------------
// Bundle of the AXI AR/R channel and the line-fetch handshake used by
// cc_line_rd_responder.
//   slave  modport : the responder (drives arready/R/line request)
//   master modport : the requester / environment side
// Signals:
//   arid_i/araddr_i/arlen_i/arsize_i/arburst_i/arvalid_i, arready_o : AR
//   rid_o/rdata_o/rresp_o/rlast_o/rvalid_o, rready_i                 : R
//   line_req_valid_o/line_req_addr_o, line_req_ready_i             : fetch req
//   line_rsp_valid_i/line_rsp_data_i                               : fetch rsp
// ============================================================================
interface cc_line_rd_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid_i;
    logic [ADDR_WIDTH-1:0] araddr_i;
    logic [3:0]            arlen_i;
    logic [2:0]            arsize_i;
    logic [1:0]            arburst_i;
    logic                  arvalid_i;
    logic                  arready_o;
    logic [ID_WIDTH-1:0]   rid_o;
    logic [63:0]           rdata_o;
    logic [1:0]            rresp_o;
    logic                  rlast_o;
    logic                  rvalid_o;
    logic                  rready_i;
    logic                  line_req_valid_o;
    logic [ADDR_WIDTH-7:0] line_req_addr_o;
    logic                  line_req_ready_i;
    logic                  line_rsp_valid_i;
    logic [511:0]          line_rsp_data_i;

    modport slave (
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
        input  rready_i, line_req_ready_i, line_rsp_valid_i, line_rsp_data_i,
        output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        output line_req_valid_o, line_req_addr_o
    );

    modport master (
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
        output rready_i, line_req_ready_i, line_rsp_valid_i, line_rsp_data_i,
        input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        input  line_req_valid_o, line_req_addr_o
    );
endinterface

// File: rtl/cc_line_rd_responder.sv
// ============================================================================
// cc_line_rd_responder
// ----------------------------------------------------------------------------
// AXI read responder for 64 B cache lines. Accepts one AR request, fetches
// the line through the line-fetch handshake and returns it as 8 x 64-bit R
// beats in critical-word-first WRAP order. Unsupported requests (anything
// other than len 7 / size 8 B / WRAP) are answered with len+1 SLVERR beats
// and no fetch.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cc_line_rd_responder_if.slave (AR, R, line request/response)
// Build option:
//   CC_LINE_RD_AR_BUF_EN : adds a one-entry AR buffer so a second request
//   can be accepted while a burst is in flight; bursts stay in AR order.
// All outputs are driven directly from registers.
// ============================================================================
module cc_line_rd_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    cc_line_rd_responder_if.slave     bus
);
    localparam int LA_W = ADDR_WIDTH - 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    function automatic logic req_supported(input logic [3:0] len,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
        return (len == 4'd7) && (size == 3'b011) && (burst == 2'b10);
    endfunction

    function automatic logic [63:0] word_sel(input logic [511:0] line,
                                             input logic [2:0]   idx);
        return line[{idx, 6'd0} +: 64];
    endfunction

    state_t              state_r, state_nxt_s;
    logic [ID_WIDTH-1:0] id_r, id_nxt_s;
    logic [3:0]          len_r, len_nxt_s;
    logic [2:0]          wptr_r, wptr_nxt_s;
    logic [3:0]          beat_r, beat_nxt_s;
    logic [511:0]        line_r, line_nxt_s;

    logic                arready_r, arready_nxt_s;
    logic                rvalid_r, rvalid_nxt_s;
    logic                rlast_r, rlast_nxt_s;
    logic [ID_WIDTH-1:0] rid_r, rid_nxt_s;
    logic [63:0]         rdata_r, rdata_nxt_s;
    logic [1:0]          rresp_r, rresp_nxt_s;
    logic                lrv_r, lrv_nxt_s;
    logic [LA_W-1:0]     lra_r, lra_nxt_s;

    logic                go_s;
    logic [ID_WIDTH-1:0] go_id_s;
    logic [LA_W-1:0]     go_laddr_s;
    logic [2:0]          go_word_s;
    logic [3:0]          go_len_s;
    logic                go_ok_s;

    logic                ar_hs_s;
    logic                r_hs_s;
    logic                unused_addr_s;

`ifdef CC_LINE_RD_AR_BUF_EN
    logic                take_buf_s;
    logic                buf_valid_r, buf_valid_nxt_s;
    logic [ID_WIDTH-1:0] buf_id_r, buf_id_nxt_s;
    logic [LA_W-1:0]     buf_laddr_r, buf_laddr_nxt_s;
    logic [2:0]          buf_word_r, buf_word_nxt_s;
    logic [3:0]          buf_len_r, buf_len_nxt_s;
    logic                buf_ok_r, buf_ok_nxt_s;
`endif

    assign ar_hs_s       = bus.arvalid_i && arready_r;
    assign r_hs_s        = rvalid_r && bus.rready_i;
    // Byte offset within a word does not affect a full-line response.
    assign unused_addr_s = ^bus.araddr_i[2:0];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, next-output and request-start decode.
    always_comb begin
        state_nxt_s   = state_r;
        id_nxt_s      = id_r;
        len_nxt_s     = len_r;
        wptr_nxt_s    = wptr_r;
        beat_nxt_s    = beat_r;
        line_nxt_s    = line_r;
        rvalid_nxt_s  = rvalid_r;
        rlast_nxt_s   = rlast_r;
        rid_nxt_s     = rid_r;
        rdata_nxt_s   = rdata_r;
        rresp_nxt_s   = rresp_r;
        lrv_nxt_s     = lrv_r;
        lra_nxt_s     = lra_r;
        arready_nxt_s = arready_r;
        go_s          = 1'b0;
        go_id_s       = bus.arid_i;
        go_laddr_s    = bus.araddr_i[ADDR_WIDTH-1:6];
        go_word_s     = bus.araddr_i[5:3];
        go_len_s      = bus.arlen_i;
        go_ok_s       = req_supported(bus.arlen_i, bus.arsize_i, bus.arburst_i);
`ifdef CC_LINE_RD_AR_BUF_EN
        take_buf_s      = 1'b0;
        buf_valid_nxt_s = buf_valid_r;
        buf_id_nxt_s    = buf_id_r;
        buf_laddr_nxt_s = buf_laddr_r;
        buf_word_nxt_s  = buf_word_r;
        buf_len_nxt_s   = buf_len_r;
        buf_ok_nxt_s    = buf_ok_r;
`endif

        case (state_r)
            ST_IDLE: begin
`ifdef CC_LINE_RD_AR_BUF_EN
                // A request buffered in the same cycle the last beat went out
                // is picked up here; arready is low while it is pending.
                if (buf_valid_r) begin
                    go_s       = 1'b1;
                    take_buf_s = 1'b1;
                end else if (ar_hs_s) begin
                    go_s = 1'b1;
                end else begin
                    go_s = 1'b0;
                end
`else
                if (ar_hs_s) begin
                    go_s = 1'b1;
                end else begin
                    go_s = 1'b0;
                end
`endif
            end
            ST_FETCH: begin
                if (lrv_r && bus.line_req_ready_i) begin
                    state_nxt_s = ST_WAIT;
                    lrv_nxt_s   = 1'b0;
                end else begin
                    lrv_nxt_s   = 1'b1;
                end
            end
            ST_WAIT: begin
                // First beat is taken straight from the incoming line so it
                // appears the cycle after the response pulse.
                if (bus.line_rsp_valid_i) begin
                    state_nxt_s  = ST_SEND;
                    line_nxt_s   = bus.line_rsp_data_i;
                    rvalid_nxt_s = 1'b1;
                    rlast_nxt_s  = 1'b0;
                    rid_nxt_s    = id_r;
                    rresp_nxt_s  = 2'b00;
                    rdata_nxt_s  = word_sel(bus.line_rsp_data_i, wptr_r);
                end else begin
                    state_nxt_s  = ST_WAIT;
                end
            end
            ST_SEND, ST_ERR: begin
                if (r_hs_s) begin
                    if (rlast_r) begin
                        state_nxt_s  = ST_IDLE;
                        rvalid_nxt_s = 1'b0;
                        rlast_nxt_s  = 1'b0;
`ifdef CC_LINE_RD_AR_BUF_EN
                        if (buf_valid_r) begin
                            go_s       = 1'b1;
                            take_buf_s = 1'b1;
                        end else begin
                            go_s       = 1'b0;
                        end
`endif
                    end else begin
                        wptr_nxt_s  = wptr_r + 3'd1;
                        beat_nxt_s  = beat_r + 4'd1;
                        rlast_nxt_s = ((beat_r + 4'd1) == len_r);
                        rdata_nxt_s = (state_r == ST_SEND) ?
                                      word_sel(line_r, wptr_r + 3'd1) : 64'd0;
                    end
                end else begin
                    rvalid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                rvalid_nxt_s = 1'b0;
                rlast_nxt_s  = 1'b0;
                lrv_nxt_s    = 1'b0;
            end
        endcase

`ifdef CC_LINE_RD_AR_BUF_EN
        if (take_buf_s) begin
            go_id_s         = buf_id_r;
            go_laddr_s      = buf_laddr_r;
            go_word_s       = buf_word_r;
            go_len_s        = buf_len_r;
            go_ok_s         = buf_ok_r;
            buf_valid_nxt_s = 1'b0;
        end else begin
            buf_valid_nxt_s = buf_valid_r;
        end
        // Requests accepted while busy are parked in the buffer.
        if (ar_hs_s && (state_r != ST_IDLE)) begin
            buf_valid_nxt_s = 1'b1;
            buf_id_nxt_s    = bus.arid_i;
            buf_laddr_nxt_s = bus.araddr_i[ADDR_WIDTH-1:6];
            buf_word_nxt_s  = bus.araddr_i[5:3];
            buf_len_nxt_s   = bus.arlen_i;
            buf_ok_nxt_s    = req_supported(bus.arlen_i, bus.arsize_i, bus.arburst_i);
        end else begin
            buf_ok_nxt_s    = buf_ok_nxt_s;
        end
`endif

        if (go_s) begin
            id_nxt_s   = go_id_s;
            len_nxt_s  = go_len_s;
            wptr_nxt_s = go_word_s;
            beat_nxt_s = 4'd0;
            if (go_ok_s) begin
                state_nxt_s  = ST_FETCH;
                lrv_nxt_s    = 1'b1;
                lra_nxt_s    = go_laddr_s;
                rvalid_nxt_s = 1'b0;
                rlast_nxt_s  = 1'b0;
            end else begin
                state_nxt_s  = ST_ERR;
                rvalid_nxt_s = 1'b1;
                rlast_nxt_s  = (go_len_s == 4'd0);
                rid_nxt_s    = go_id_s;
                rdata_nxt_s  = 64'd0;
                rresp_nxt_s  = 2'b10;
            end
        end else begin
            id_nxt_s = id_nxt_s;
        end

`ifdef CC_LINE_RD_AR_BUF_EN
        arready_nxt_s = !buf_valid_nxt_s;
`else
        arready_nxt_s = (state_nxt_s == ST_IDLE);
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r      <= '0;
            len_r     <= 4'd0;
            wptr_r    <= 3'd0;
            beat_r    <= 4'd0;
            line_r    <= 512'd0;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= 64'd0;
            rresp_r   <= 2'b00;
            lrv_r     <= 1'b0;
            lra_r     <= '0;
        end else begin
            id_r      <= id_nxt_s;
            len_r     <= len_nxt_s;
            wptr_r    <= wptr_nxt_s;
            beat_r    <= beat_nxt_s;
            line_r    <= line_nxt_s;
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            rlast_r   <= rlast_nxt_s;
            rid_r     <= rid_nxt_s;
            rdata_r   <= rdata_nxt_s;
            rresp_r   <= rresp_nxt_s;
            lrv_r     <= lrv_nxt_s;
            lra_r     <= lra_nxt_s;
        end
    end

`ifdef CC_LINE_RD_AR_BUF_EN
    // One-entry AR buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_id_r    <= '0;
            buf_laddr_r <= '0;
            buf_word_r  <= 3'd0;
            buf_len_r   <= 4'd0;
            buf_ok_r    <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_nxt_s;
            buf_id_r    <= buf_id_nxt_s;
            buf_laddr_r <= buf_laddr_nxt_s;
            buf_word_r  <= buf_word_nxt_s;
            buf_len_r   <= buf_len_nxt_s;
            buf_ok_r    <= buf_ok_nxt_s;
        end
    end
`endif

    assign bus.arready_o        = arready_r;
    assign bus.rvalid_o         = rvalid_r;
    assign bus.rlast_o          = rlast_r;
    assign bus.rid_o            = rid_r;
    assign bus.rdata_o          = rdata_r;
    assign bus.rresp_o          = rresp_r;
    assign bus.line_req_valid_o = lrv_r;
    assign bus.line_req_addr_o  = lra_r;
endmodule

// File: tb/tb_cc_line_rd_responder.sv
module tb_cc_line_rd_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cc_line_rd_responder_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) bus ();
    cc_line_rd_responder #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        bit          ok;
        logic [25:0] laddr;
        int          dly;
        bit          bp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t sbq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beats_seen = 0;
    int lreq_cycles = 0;
    int last_hs_cyc = -1;
    int lreq_rise_cyc = -2;
    bit bp_mode = 1'b0;
    int rr_idx = 0;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input int vi, input int k);
        return {16'hCAFE, 8'(vi), 8'(k), 32'h0123_4567 + 32'(vi * 8 + k)};
    endfunction

    function automatic logic [511:0] mk_line(input int vi);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = mk_word(vi, k);
        return l;
    endfunction

    task automatic push_expected(input vec_t v, input int vi);
        beat_t b;
        logic [2:0] w;
        for (int k = 0; k <= int'(v.len); k++) begin
            w = v.addr[5:3] + 3'(k);
            b.data = v.ok ? mk_word(vi, int'(w)) : 64'd0;
            b.resp = v.ok ? 2'b00 : 2'b10;
            b.last = (k == int'(v.len));
            b.id   = v.id;
            sbq.push_back(b);
        end
    endtask

    task automatic drive_ar(input vec_t v);
        bus.arid_i    = v.id;
        bus.araddr_i  = v.addr;
        bus.arlen_i   = v.len;
        bus.arsize_i  = v.size;
        bus.arburst_i = v.burst;
        bus.arvalid_i = 1'b1;
    endtask

    task automatic do_ar(input vec_t v);
        bit hs = 1'b0;
        int n = 0;
        drive_ar(v);
        while (!hs && n < 50) begin
            hs = bus.arready_o;
            step();
            n++;
        end
        bus.arvalid_i = 1'b0;
        chk("ar_accept", 64'(hs), 64'd1);
    endtask

    task automatic wait_lreq();
        int n = 0;
        while (!bus.line_req_valid_o && n < 50) begin
            step();
            n++;
        end
        chk("lreq_seen", 64'(bus.line_req_valid_o), 64'd1);
    endtask

    task automatic serve_fetch(input vec_t v, input int vi);
        wait_lreq();
        chk("lreq_addr", 64'(bus.line_req_addr_o), 64'(v.laddr));
        for (int d = 0; d < v.dly; d++) begin
            step();
            chk("lreq_hold", 64'(bus.line_req_valid_o), 64'd1);
            chk("lreq_addr_stable", 64'(bus.line_req_addr_o), 64'(v.laddr));
        end
        bus.line_req_ready_i = 1'b1;
        step();
        bus.line_req_ready_i = 1'b0;
        chk("lreq_drop", 64'(bus.line_req_valid_o), 64'd0);
        step();
        step();
        chk("no_rvalid_in_wait", 64'(bus.rvalid_o), 64'd0);
        bus.line_rsp_valid_i = 1'b1;
        bus.line_rsp_data_i  = mk_line(vi);
        step();
        bus.line_rsp_valid_i = 1'b0;
        bus.line_rsp_data_i  = 512'd0;
        chk("first_rvalid", 64'(bus.rvalid_o), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
        chk("rearm_arready", 64'(bus.arready_o), 64'd1);
        chk("idle_rvalid", 64'(bus.rvalid_o), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // rready: constant 1, or the repeating 1,0,0,1 pattern
    initial begin
        bus.rready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.rready_i = ((rr_idx % 4) == 0) || ((rr_idx % 4) == 3);
                rr_idx++;
            end else begin
                bus.rready_i = 1'b1;
            end
        end
    end

    // R monitor and scoreboard
    initial begin
        bit prev_stall = 1'b0;
        bit prev_lrv = 1'b0;
        logic [63:0] prev_data = 64'd0;
        logic prev_last = 1'b0;
        logic [3:0] prev_id = 4'd0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_lrv   = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.rvalid_o), 64'd1);
                    chk("stall_data", bus.rdata_o, prev_data);
                    chk("stall_last", 64'(bus.rlast_o), 64'(prev_last));
                    chk("stall_id", 64'(bus.rid_o), 64'(prev_id));
                end
                if (bus.line_req_valid_o) lreq_cycles++;
                if (bus.line_req_valid_o && !prev_lrv) lreq_rise_cyc = cyc;
                prev_lrv = bus.line_req_valid_o;
                if (bus.rvalid_o && bus.rready_i) begin
                    if (sbq.size() == 0) begin
                        chk("extra_beat", 64'd0, 64'd1);
                    end else begin
                        b = sbq.pop_front();
                        chk("rdata", bus.rdata_o, b.data);
                        chk("rresp", 64'(bus.rresp_o), 64'(b.resp));
                        chk("rlast", 64'(bus.rlast_o), 64'(b.last));
                        chk("rid", 64'(bus.rid_o), 64'(b.id));
                    end
                    beats_seen++;
                    if (bus.rlast_o) last_hs_cyc = cyc + 1;
                end
                prev_stall = bus.rvalid_o && !bus.rready_i;
                prev_data  = bus.rdata_o;
                prev_last  = bus.rlast_o;
                prev_id    = bus.rid_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        vecs[0] = '{id:4'h3, addr:32'h0000_1240, len:4'd7, size:3'b011, burst:2'b10, ok:1'b1, laddr:26'h49,      dly:0, bp:1'b0};
        vecs[1] = '{id:4'h5, addr:32'h0000_1268, len:4'd7, size:3'b011, burst:2'b10, ok:1'b1, laddr:26'h49,      dly:1, bp:1'b0};
        vecs[2] = '{id:4'hA, addr:32'h8000_0038, len:4'd7, size:3'b011, burst:2'b10, ok:1'b1, laddr:26'h200_0000, dly:3, bp:1'b1};
        vecs[3] = '{id:4'h1, addr:32'h0000_0100, len:4'd3, size:3'b011, burst:2'b01, ok:1'b0, laddr:26'h0,        dly:0, bp:1'b0};
        vecs[4] = '{id:4'h2, addr:32'h0000_0000, len:4'd7, size:3'b010, burst:2'b10, ok:1'b0, laddr:26'h0,        dly:0, bp:1'b1};
        vecs[5] = '{id:4'hF, addr:32'hFFFF_FFC8, len:4'd7, size:3'b011, burst:2'b10, ok:1'b1, laddr:26'h3FF_FFFF, dly:2, bp:1'b1};
        vecs[6] = '{id:4'h7, addr:32'h0000_0040, len:4'd0, size:3'b011, burst:2'b00, ok:1'b0, laddr:26'h0,        dly:0, bp:1'b0};

        rst = 1'b1;
        bus.arid_i = 4'd0; bus.araddr_i = 32'd0; bus.arlen_i = 4'd0;
        bus.arsize_i = 3'd0; bus.arburst_i = 2'd0; bus.arvalid_i = 1'b0;
        bus.line_req_ready_i = 1'b0; bus.line_rsp_valid_i = 1'b0; bus.line_rsp_data_i = 512'd0;
        step();
        step();
        chk("rst_arready", 64'(bus.arready_o), 64'd1);
        chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("rst_rlast", 64'(bus.rlast_o), 64'd0);
        chk("rst_lreq_valid", 64'(bus.line_req_valid_o), 64'd0);
        chk("rst_rid", 64'(bus.rid_o), 64'd0);
        chk("rst_rdata", bus.rdata_o, 64'd0);
        chk("rst_rresp", 64'(bus.rresp_o), 64'd0);
        chk("rst_lreq_addr", 64'(bus.line_req_addr_o), 64'd0);
        rst = 1'b0;
        step();

        // stray line response while idle must be ignored
        bus.line_rsp_valid_i = 1'b1;
        bus.line_rsp_data_i  = mk_line(99);
        step();
        bus.line_rsp_valid_i = 1'b0;
        step();
        chk("stray_rsp_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("stray_rsp_arready", 64'(bus.arready_o), 64'd1);

        for (int vi = 0; vi < 7; vi++) begin
            bp_mode = vecs[vi].bp;
            rr_idx = 0;
            lreq_cycles = 0;
            do_ar(vecs[vi]);
            push_expected(vecs[vi], vi);
            if (vecs[vi].ok) begin
                chk("lreq_next_cycle", 64'(bus.line_req_valid_o), 64'd1);
                serve_fetch(vecs[vi], vi);
            end else begin
                chk("err_first_rvalid", 64'(bus.rvalid_o), 64'd1);
            end
            wait_drain();
            if (!vecs[vi].ok) chk("err_no_lreq", 64'(lreq_cycles), 64'd0);
            bp_mode = 1'b0;
            step();
        end

        // reset in the middle of a burst
        bp_mode = 1'b0;
        base = beats_seen;
        do_ar(vecs[1]);
        push_expected(vecs[1], 1);
        serve_fetch(vecs[1], 1);
        n = 0;
        while (beats_seen < base + 4 && n < 50) begin
            step();
            n++;
        end
        chk("midburst_beats", 64'(beats_seen - base), 64'd4);
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("midrst_arready", 64'(bus.arready_o), 64'd1);
        chk("midrst_rlast", 64'(bus.rlast_o), 64'd0);
        sbq.delete();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_quiet", 64'(beats_seen - base), 64'd4);
        do_ar(vecs[0]);
        push_expected(vecs[0], 0);
        serve_fetch(vecs[0], 0);
        wait_drain();

`ifdef CC_LINE_RD_AR_BUF_EN
        // buffered second request, third blocked until the buffer drains
        step();
        do_ar(vecs[0]);
        push_expected(vecs[0], 10);
        wait_lreq();
        bus.line_req_ready_i = 1'b1;
        step();
        bus.line_req_ready_i = 1'b0;
        chk("buf_arready_in_wait", 64'(bus.arready_o), 64'd1);
        do_ar(vecs[5]);
        push_expected(vecs[5], 11);
        drive_ar(vecs[3]);
        step();
        chk("buf_full_block", 64'(bus.arready_o), 64'd0);
        bus.line_rsp_valid_i = 1'b1;
        bus.line_rsp_data_i  = mk_line(10);
        step();
        bus.line_rsp_valid_i = 1'b0;
        chk("buf_full_block2", 64'(bus.arready_o), 64'd0);
        n = 0;
        while (!bus.line_req_valid_o && n < 50) begin
            step();
            n++;
        end
        chk("buf_fetch_timing", 64'(lreq_rise_cyc), 64'(last_hs_cyc));
        chk("buf_b_addr", 64'(bus.line_req_addr_o), 64'(vecs[5].laddr));
        do_ar(vecs[3]);
        push_expected(vecs[3], 12);
        bus.line_req_ready_i = 1'b1;
        step();
        bus.line_req_ready_i = 1'b0;
        step();
        bus.line_rsp_valid_i = 1'b1;
        bus.line_rsp_data_i  = mk_line(11);
        step();
        bus.line_rsp_valid_i = 1'b0;
        wait_drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cc_line_rd_responder.md
Name: cc_line_rd_responder

Overview:
- AXI read-responder slice on the interconnect side of the cache controller: accepts one AR request at a time and fetches the addressed 64 B line through a line-fetch handshake.
- Returns the line as 8 × 64-bit R beats in critical-word-first WRAP order.
- Forms the responding end of the INCT AR/R channel that the cache-controller bench drives and monitors.

Parameters:
- ID_WIDTH, 4, width of arid/rid
- ADDR_WIDTH, 32, width of araddr; line address is araddr[ADDR_WIDTH-1:6]

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- arid_i  in  ID_WIDTH  request ID
- araddr_i  in  ADDR_WIDTH  byte address; [5:3] selects the first word
- arlen_i  in  4  beats minus 1; only 7 supported
- arsize_i  in  3  only 3'b011 (8 B) supported
- arburst_i  in  2  only 2'b10 (WRAP) supported
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rid_o  out  ID_WIDTH  echoes the accepted arid
- rdata_o  out  64  beat data
- rresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast_o  out  1  final beat
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready
- line_req_valid_o  out  1  line fetch request
- line_req_addr_o  out  ADDR_WIDTH-6  line address
- line_req_ready_i  in  1  fetch request accepted
- line_rsp_valid_i  in  1  line data valid; one-cycle pulse
- line_rsp_data_i  in  512  line data; word w = bits [64w+63:64w]

Behaviour:
- Reset (async, active-high): state IDLE; arready_o=1; rvalid_o=0; rlast_o=0; line_req_valid_o=0; rid_o, rdata_o, rresp_o, line_req_addr_o = 0.
- States: IDLE, FETCH, WAIT, SEND, ERR.
- IDLE:
  - arready_o=1.
  - On arvalid_i&&arready_o, latch id, addr, len. Start word s=araddr_i[5:3].
  - Supported request (len 7, size 3, WRAP) -> FETCH. Otherwise -> ERR.
- FETCH:
  - line_req_valid_o=1 with line_req_addr_o stable, held until line_req_ready_i.
  - Then -> WAIT.
  - The first line_req_valid_o is asserted the cycle after the AR handshake.
- WAIT:
  - On line_rsp_valid_i, register all 512 bits -> SEND.
  - A line_rsp_valid_i pulse in any other state is ignored.
- SEND:
  - rvalid_o=1, rresp_o=OKAY. Beat k (0..7) drives word (s+k) mod 8, using a 3-bit wrap counter.
  - First rvalid_o appears the cycle after line_rsp_valid_i.
  - rdata_o, rid_o and rlast_o stay stable while rvalid_o && !rready_i.
  - Beat advances only on rvalid_o&&rready_i.
  - rlast_o=1 on k=7 only. After that beat is accepted -> IDLE.
  - rvalid_o may be held for consecutive beats: full throughput 1 beat/cycle when rready_i=1.
- ERR:
  - No line fetch is issued. Emit len+1 beats with rdata_o=0, rresp_o=SLVERR, rlast_o on the final beat, same handshake rules as SEND.
  - Then -> IDLE.
- arready_o=0 in every state except IDLE, so one outstanding request maximum.
- Earliest re-accept is the cycle after the last R handshake.
- Reset mid-burst: the burst is abandoned, all outputs return to reset values immediately, and no further beats are emitted.

Optional Feature:
- Macro: CC_LINE_RD_AR_BUF_EN.
- Defined:
  - One-entry AR buffer. arready_o=1 whenever the buffer is empty, including during FETCH/WAIT/SEND/ERR.
  - A buffered request starts (FETCH or ERR) in the cycle after the previous burst's rlast handshake, without passing through IDLE.
  - Buffer full -> arready_o=0.
  - R ordering is strictly in AR acceptance order.
- Undefined: single-outstanding behaviour exactly as above.

Test Plan:
- Aligned: araddr=0x0000_1240, arid=3, len 7, WRAP; line words W0..W7 -> 8 beats W0..W7, rid=3, rresp=0, rlast on beat 7 only, line_req_addr_o=0x49.
- Wrap: araddr=0x0000_1268 (s=5) -> beat order W5,W6,W7,W0,W1,W2,W3,W4.
- Backpressure:
  - rready_i toggles 1,0,0,1,… with line_req_ready_i delayed 3 cycles.
  - Data and rlast are stable during stalls, no beat is lost or duplicated, and line_req_valid_o is held for the 3 cycles.
- Unsupported request: arburst=2'b01, arlen=3 -> no line_req_valid_o; 4 beats of rdata=0, rresp=2'b10, rlast on beat 3.
- Reset mid-burst: assert rst after beat 3 -> rvalid_o=0 and arready_o=1 immediately. A new request after reset is served correctly from beat 0.
- With CC_LINE_RD_AR_BUF_EN:
  - Second AR is accepted during WAIT of the first.
  - The second burst's FETCH begins the cycle after the first rlast handshake.
  - Third AR sees arready_o=0 until the buffer drains.
